// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency signed multiplier among
// NUM_REQ requesters and returns each product with its requester id.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           mult_a,
    output logic [DATA_W-1:0]           mult_b,
    input  logic [2*DATA_W-1:0]         mult_result,
    output logic                        resp_valid,
    output logic [ID_W-1:0]             resp_id,
    output logic [2*DATA_W-1:0]         resp_data,
    input  logic                        resp_ready,
    output logic                        busy
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [CNT_W-1:0]  counter;
    logic              found;
    logic [ID_W-1:0]   winner;
    logic              accept;
    logic              capture;
    logic              handshake;
    int                idx;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (found && !rst) begin
                    req_ready[winner] = 1'b1;
                    accept            = 1'b1;
                    state_next        = WAIT;
                end
            end
            WAIT: begin
                if (counter == '0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands stay parked on the multiplier between transactions so its inputs never toggle idly.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            grant_id   <= '0;
            counter    <= '0;
            mult_a     <= '0;
            mult_b     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else begin
            if (accept) begin
                mult_a   <= req_a[int'(winner)*DATA_W +: DATA_W];
                mult_b   <= req_b[int'(winner)*DATA_W +: DATA_W];
                grant_id <= winner;
                counter  <= CNT_INIT;
            end else if (state == WAIT && counter != '0) begin
                counter <= counter - 1'b1;
            end
            if (capture) begin
                resp_data  <= mult_result;
                resp_id    <= grant_id;
                resp_valid <= 1'b1;
            end
            // Pointer moves only on completion, so the finished requester drops to lowest priority.
            if (handshake) begin
                resp_valid <= 1'b0;
                rr_ptr     <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
